// File: rtl/sr_cmd_driver_pkg.sv
// Shared types and encodings for the SR command driver.
// Provides the driver FSM state type and the S/R pair encodings.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        CHECK = 2'd3
    } sr_state_t;

    // {S, R} encodings
    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_CLR     = 2'b01;
    localparam logic [1:0] SR_INVALID = 2'b11;

    // Legal pulse encoding that drives Q towards the given level.
    function automatic logic [1:0] sr_encode(input logic level);
        return level ? SR_SET : SR_CLR;
    endfunction

endpackage

// File: rtl/sr_cmd_driver_hold_counter.sv
// sr_hold_counter: loadable down-counter with a zero flag.
// Saturates at zero so an unattended decrement never wraps.
module sr_hold_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over decrement; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sr_cmd_driver.sv
// sr_cmd_driver: turns a valid/ready stream of {level, hold} commands into
// legal S/R pulses for an SR register, tracking a shadow of the expected Q.
// Optional feedback check of Q is enabled by defining SR_CMD_DRIVER_FBCHK_EN.
module sr_cmd_driver
    import sr_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PULSE_CYC = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_level,
    input  logic [CNT_W-1:0] in_dur,
    output logic             S,
    output logic             R,
    input  logic             q_fb,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             mismatch_clr
);

    // Counter holds (remaining cycles - 1), so zero flags the last cycle of a phase.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);

    sr_state_t        r_state;
    sr_state_t        w_next_state;
    logic [1:0]       r_sr;
    logic [1:0]       w_next_sr;
    logic             r_done;
    logic             r_busy;
    logic             r_shadow;
    logic             r_level;
    logic [CNT_W-1:0] r_dur;
    logic             w_hs;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_zero;

    assign in_ready = (r_state == IDLE) && reset_n;
    assign w_hs     = in_valid && in_ready;

    sr_hold_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_dec      (w_cnt_dec),
        .i_load_val (w_cnt_val),
        .o_zero     (w_cnt_zero)
    );

    // Next-state, next S/R pair and counter control.
    always_comb begin
        w_next_state = r_state;
        w_next_sr    = SR_HOLD;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_cnt_val    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_hs) begin
                    if (in_level != r_shadow) begin
                        w_next_state = PULSE;
                        w_next_sr    = sr_encode(in_level);
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = PULSE_LOAD;
                    end else if (in_dur == '0) begin
                        w_next_state = CHECK;
                    end else begin
                        w_next_state = HOLD;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = in_dur - CNT_W'(1);
                    end
                end
            end
            PULSE: begin
                if (!w_cnt_zero) begin
                    w_next_sr = sr_encode(r_level);
                    w_cnt_dec = 1'b1;
                end else if (r_dur == '0) begin
                    w_next_state = CHECK;
                end else begin
                    w_next_state = HOLD;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = r_dur - CNT_W'(1);
                end
            end
            HOLD: begin
                if (w_cnt_zero) begin
                    w_next_state = CHECK;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            CHECK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, registered outputs and the latched command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sr     <= SR_HOLD;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_shadow <= 1'b0;
            r_level  <= 1'b0;
            r_dur    <= '0;
        end else begin
            r_state <= w_next_state;
            r_sr    <= w_next_sr;
            r_done  <= (w_next_state == CHECK);
            r_busy  <= (w_next_state != IDLE);
            if (w_hs) begin
                r_level <= in_level;
                r_dur   <= in_dur;
                if (in_level != r_shadow) begin
                    r_shadow <= in_level;
                end
            end
        end
    end

    assign S    = r_sr[1];
    assign R    = r_sr[0];
    assign busy = r_busy;
    assign done = r_done;

`ifdef SR_CMD_DRIVER_FBCHK_EN
    logic r_mismatch;
    logic w_mm_set;

    assign w_mm_set = (r_state == CHECK) && (q_fb != r_shadow);

    // Sticky feedback error; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mismatch <= 1'b0;
        end else if (w_mm_set) begin
            r_mismatch <= 1'b1;
        end else if (mismatch_clr) begin
            r_mismatch <= 1'b0;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_fb;

    assign w_unused_fb = q_fb ^ mismatch_clr;
    assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Self-checking bench for sr_cmd_driver (CNT_W=8, PULSE_CYC=1).
// Mismatch expectations follow SR_CMD_DRIVER_FBCHK_EN when it is defined.
module tb_sr_cmd_driver;

    localparam int CNT_W     = 8;
    localparam int PULSE_CYC = 1;
`ifdef SR_CMD_DRIVER_FBCHK_EN
    localparam logic FB = 1'b1;
`else
    localparam logic FB = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_level;
    logic [CNT_W-1:0] in_dur;
    logic             S;
    logic             R;
    logic             q_fb;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic             mismatch_clr;

    logic q_reg;
    logic force0;

    int n_cmp;
    int n_err;
    int sr_both;
    int ready_bad;

    sr_cmd_driver #(
        .CNT_W     (CNT_W),
        .PULSE_CYC (PULSE_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_level     (in_level),
        .in_dur       (in_dur),
        .S            (S),
        .R            (R),
        .q_fb         (q_fb),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_clr (mismatch_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural SR register downstream of the driver.
    always @(posedge clk) begin
        if (!reset_n)  q_reg <= 1'b0;
        else if (S)    q_reg <= 1'b1;
        else if (R)    q_reg <= 1'b0;
    end
    assign q_fb = force0 ? 1'b0 : q_reg;

    // Per-cycle invariants: never S&R, in_ready tracks reset and idle.
    initial begin
        sr_both   = 0;
        ready_bad = 0;
    end
    always @(posedge clk) begin
        #2;
        if (S === 1'b1 && R === 1'b1) sr_both++;
        if (in_ready !== (reset_n && !busy)) ready_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one command and check pulses, done latency and re-ready.
    task automatic run_cmd(input logic level, input int dur, input int lat,
                           input int s_n, input int r_n, input logic shadow);
        int  k;
        int  scnt;
        int  rcnt;
        int  late;
        int  early;
        bit  got;
        chk("ready_before_cmd", in_ready, 1);
        in_valid = 1'b1;
        in_level = level;
        in_dur   = CNT_W'(dur);
        tick();
        in_valid = 1'b0;
        k = 0; scnt = 0; rcnt = 0; late = 0; early = 0; got = 0;
        while (!got && k < lat + 20) begin
            k++;
            if (S) begin scnt++; if (k > PULSE_CYC) late++; end
            if (R) begin rcnt++; if (k > PULSE_CYC) late++; end
            if (in_ready) early++;
            if (done) got = 1;
            else tick();
        end
        chk("done_seen", got, 1);
        chk("done_latency", k, lat);
        chk("s_pulse_cycles", scnt, s_n);
        chk("r_pulse_cycles", rcnt, r_n);
        chk("pulse_outside_window", late, 0);
        chk("ready_during_cmd", early, 0);
        chk("shadow_after", dut.r_shadow, shadow);
        tick();
        chk("done_one_cycle", done, 0);
        chk("ready_after_cmd", in_ready, 1);
    endtask

    typedef struct {
        logic level;
        int   dur;
        int   lat;
        int   s_n;
        int   r_n;
        logic shadow;
    } vec_t;

    vec_t vt[8];

    initial begin
        int la[3];
        int pk[4];
        int np;
        int dt[4];
        int nd;
        int idx;
        bit prev_ready;
        bit prev_s;
        bit prev_r;
        int bad;

        // level, dur, latency, S cycles, R cycles, shadow afterwards
        vt[0] = '{1'b1,   3,   5, 1, 0, 1'b1};
        vt[1] = '{1'b1,   0,   1, 0, 0, 1'b1};
        vt[2] = '{1'b0,   2,   4, 0, 1, 1'b0};
        vt[3] = '{1'b0,   1,   2, 0, 0, 1'b0};
        vt[4] = '{1'b1,   0,   2, 1, 0, 1'b1};
        vt[5] = '{1'b1, 255, 256, 0, 0, 1'b1};
        vt[6] = '{1'b0, 255, 257, 0, 1, 1'b0};
        vt[7] = '{1'b0,   0,   1, 0, 0, 1'b0};

        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; in_valid = 1'b0; in_level = 1'b0; in_dur = '0;
        mismatch_clr = 1'b0; force0 = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_shadow", dut.r_shadow, 0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_release", in_ready, 1);

        // Table-driven single commands, including the 255-cycle hold
        for (int i = 0; i < 8; i++) begin
            run_cmd(vt[i].level, vt[i].dur, vt[i].lat, vt[i].s_n, vt[i].r_n, vt[i].shadow);
            chk("mismatch_clean_fb", mismatch, 0);
        end

        // Back-to-back 1,0,1 with in_valid held high
        la[0] = 1; la[1] = 0; la[2] = 1;
        np = 0; nd = 0; idx = 0; bad = 0;
        in_valid = 1'b1; in_level = 1'b1; in_dur = CNT_W'(2);
        prev_ready = in_ready; prev_s = S; prev_r = R;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (S && !prev_s && np < 4) begin pk[np] = 1; np++; end
            if (R && !prev_r && np < 4) begin pk[np] = 2; np++; end
            if (done && nd < 4) begin dt[nd] = t; nd++; end
            if (busy && in_ready) bad++;
            if (prev_ready && in_valid) begin
                idx++;
                if (idx == 3) in_valid = 1'b0;
                else in_level = la[idx][0];
            end
            prev_ready = in_ready; prev_s = S; prev_r = R;
        end
        chk("b2b_pulse_count", np, 3);
        chk("b2b_pulse0_is_S", pk[0], 1);
        chk("b2b_pulse1_is_R", pk[1], 2);
        chk("b2b_pulse2_is_S", pk[2], 1);
        chk("b2b_done_count", nd, 3);
        chk("b2b_done0_cycle", dt[0], 4);
        chk("b2b_done1_cycle", dt[1], 9);
        chk("b2b_done2_cycle", dt[2], 14);
        chk("b2b_ready_while_busy", bad, 0);
        chk("b2b_shadow", dut.r_shadow, 1);

        // Feedback check: Q stuck at 0 while commanding level 1
        run_cmd(1'b0, 0, 2, 0, 1, 1'b0);
        force0 = 1'b1;
        run_cmd(1'b1, 1, 3, 1, 0, 1'b1);
        chk("fb_mismatch_set", mismatch, FB);
        repeat (3) tick();
        chk("fb_mismatch_sticky", mismatch, FB);
        mismatch_clr = 1'b1;
        tick();
        mismatch_clr = 1'b0;
        chk("fb_mismatch_cleared", mismatch, 0);
        in_valid = 1'b1; in_level = 1'b1; in_dur = '0;
        tick();
        in_valid = 1'b0;
        chk("fb_check_cycle_done", done, 1);
        mismatch_clr = 1'b1;
        tick();
        mismatch_clr = 1'b0;
        chk("fb_set_beats_clear", mismatch, FB);
        force0 = 1'b0;
        tick();

        // Reset in the middle of a long hold
        run_cmd(1'b0, 0, 2, 0, 1, 1'b0);
        in_valid = 1'b1; in_level = 1'b1; in_dur = CNT_W'(200);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("midhold_busy", busy, 1);
        chk("midhold_shadow", dut.r_shadow, 1);
        reset_n = 1'b0;
        tick();
        chk("abort_S", S, 0);
        chk("abort_R", R, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_shadow", dut.r_shadow, 0);
        chk("abort_ready", in_ready, 0);
        chk("abort_mismatch", mismatch, 0);
        reset_n = 1'b1;
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (done || busy || !in_ready) bad++;
        end
        chk("abort_quiet_after", bad, 0);

        chk("never_S_and_R", sr_both, 0);
        chk("ready_decode", ready_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
